ifetch_in_if: RTL and testbench
===============================

# ifetch_in_if

Instruction-fetch engine of the IF stage. It sits directly downstream of the PC register and takes one fetch address per handshake from it. It issues the address on the instruction-SRAM request/response bus and buffers the returned instruction words in a 2-entry queue. The ID stage pops the queue. A flush from branch or exception resolution discards queued and in-flight fetches.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pc_in` in 32: fetch address from the PC register.
- `pc_valid` in 1: `pc_in` is valid.
- `pc_accept` out 1: combinational. The address is taken this cycle and the PC register advances.
- `flush` in 1: kill all queued and in-flight fetches.
- `inst_req` out 1: bus request.
- `inst_addr` out 32: bus address.
- `inst_addr_ok` in 1: address accepted.
- `inst_data_ok` in 1: read data valid.
- `inst_rdata` in 32: instruction word.
- `id_valid` out 1: queue head is valid.
- `id_ready` in 1: ID consumes the head.
- `id_pc` out 32: PC of the head entry.
- `id_inst` out 32: instruction of the head entry.
- `id_adel` out 1: the head entry is an address-error fetch.

## Operation
- **Bus rule:** at most one bus transaction is outstanding.
- **Issue condition:** a fetch may start only if `count + inflight < 2`, where `inflight` = state is REQ or WAIT.
- **Address register:** `req_pc` (32 bits) holds the address being fetched. `inst_addr` = `req_pc`. `inst_req` = (state == REQ).
- **IDLE**
  - If `pc_valid` and the issue condition holds and `!flush`: `pc_accept` = 1, `req_pc` <= `pc_in`, go to REQ.
  - Otherwise `pc_accept` = 0.
- **REQ**
  - `inst_addr_ok` and `!flush`: go to WAIT.
  - `inst_addr_ok` and `flush`: go to DISCARD.
  - `flush` without `inst_addr_ok`: go to IDLE (request withdrawn).
- **WAIT**
  - `inst_data_ok` and `!flush`: push {`req_pc`, `inst_rdata`, 0} to the queue, go to IDLE.
  - `flush` with or without `inst_data_ok`: if `inst_data_ok` is high the same cycle, go to IDLE with no push. Otherwise go to DISCARD.
- **DISCARD:** on `inst_data_ok`, drop the data and go to IDLE. `flush` in this state has no further effect.
- **Queue**
  - 2 entries, 1-bit read and write pointers, `count` 0..2.
  - `id_valid` = (`count` != 0). `id_pc`, `id_inst` and `id_adel` come from the head entry.
  - Pop = `id_valid & id_ready`.
  - Push and pop in the same cycle: `count` is unchanged.
  - Overflow is impossible because space is reserved at issue.
- **Flush priority:** `flush` has priority over push and pop. `count` <= 0 and both pointers <= 0.
- **`pc_accept` conditions:** never asserted during `reset`, during `flush`, or outside IDLE.

## Timing
- **Reset values:** state IDLE, `count` 0, pointers 0, `req_pc` 0, all queue entries 0. Outputs: `inst_req` 0, `inst_addr` 0, `id_valid` 0, `id_pc` 0, `id_inst` 0, `id_adel` 0.
- **Reset mid-transaction:** an asserted `reset` returns to IDLE immediately. A late `inst_data_ok` after reset is ignored because the state is IDLE.
- **Minimum latency**, with accept in cycle 0:
  - cycle 1: `inst_req` = 1 with `addr_ok`.
  - cycle 2: `data_ok`, push.
  - cycle 3: `id_valid` = 1.
- **Peak throughput:** one fetch per 3 cycles.
- **Flush effects:** `id_valid` drops the cycle after a `flush`. No stale instruction ever reaches ID after a `flush`.

## Configuration
- **`IF_ALIGN_CHECK_EN` defined**
  - In IDLE, if `pc_in[1:0]` != 0 and `count < 2` and no fetch is in flight and `!flush`: `pc_accept` = 1 and push {`pc_in`, 32'h0, 1} directly.
  - No bus request is made for that address and the state stays IDLE.
- **`IF_ALIGN_CHECK_EN` undefined:** all addresses go to the bus unchanged and `id_adel` is a constant 0.

## Test plan
- Reset mid-WAIT, then release; `inst_data_ok` pulses later -> `id_valid` stays 0 and the queue stays empty.
- `pc_in` = 32'hbfc00000, `pc_valid` = 1, immediate `addr_ok`/`data_ok`, `inst_rdata` = 32'h24080001 -> cycle 3: `id_valid` = 1, `id_pc` = bfc00000, `id_inst` = 24080001.
- `id_ready` = 0 with consecutive PCs bfc00000/04/08 -> two entries queue. `pc_accept` stays 0 for 08 until a pop. Popping delivers 00 then 04 in order.
- `flush` in WAIT; `data_ok` arrives 2 cycles later with 32'hdeadbeef -> DISCARD, word dropped, `id_valid` 0. The next fetch proceeds normally.
- `flush` on the same cycle as a pop and a push at `count` = 1 -> `count` = 0 next cycle, and the pushed word is lost.
- With `IF_ALIGN_CHECK_EN`, `pc_in` = 32'hbfc00002 -> no `inst_req`. The next cycle: `id_valid` = 1, `id_adel` = 1, `id_inst` = 0, `id_pc` = bfc00002.

Source files
------------

// File: rtl/ifetch_in_if_if.sv
// Fetch-engine bus bundle: PC handshake, instruction-SRAM req/resp bus, and ID-stage queue head.
interface ifetch_in_if_if;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_accept;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    modport master (
        input  pc_in, pc_valid, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
        output pc_accept, inst_req, inst_addr, id_valid, id_pc, id_inst, id_adel
    );

    modport slave (
        output pc_in, pc_valid, flush, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
        input  pc_accept, inst_req, inst_addr, id_valid, id_pc, id_inst, id_adel
    );
endinterface

// File: rtl/ifetch_in_if.sv
// IF-stage fetch engine: one outstanding SRAM fetch, 2-entry instruction queue, flush kill.
// Optional IF_ALIGN_CHECK_EN: misaligned PCs bypass the bus as address-error queue entries.
module ifetch_in_if (
    input logic            clk,
    input logic            reset,
    ifetch_in_if_if.master bus
);
    localparam int unsigned DEPTH = 2;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } entry_t;

    state_t      state, state_nx;
    logic [31:0] req_pc, req_pc_nx;
    entry_t      q [DEPTH];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic        inflight;
    logic        issue_ok;
    logic        misaligned;
    logic        accept;
    logic        push;
    logic        pop;
    entry_t      push_entry;
    entry_t      head;

`ifdef IF_ALIGN_CHECK_EN
    assign misaligned = (bus.pc_in[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Queue space is reserved at issue so a returning word always has a slot.
    assign inflight = (state == REQ) || (state == WAIT);
    assign issue_ok = (3'(count) + 3'(inflight)) < 3'(DEPTH);

    assign head           = q[rd_ptr];
    assign pop            = (count != 2'd0) && bus.id_ready;
    assign bus.pc_accept  = accept;
    assign bus.inst_req   = (state == REQ);
    assign bus.inst_addr  = req_pc;
    assign bus.id_valid   = (count != 2'd0);
    assign bus.id_pc      = head.pc;
    assign bus.id_inst    = head.inst;
    assign bus.id_adel    = head.adel;

    always_comb begin
        state_nx   = state;
        req_pc_nx  = req_pc;
        accept     = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        case (state)
            IDLE: begin
                if (!reset && !bus.flush && bus.pc_valid && issue_ok) begin
                    accept = 1'b1;
                    if (misaligned) begin
                        push       = 1'b1;
                        push_entry = '{pc: bus.pc_in, inst: 32'h0, adel: 1'b1};
                    end else begin
                        req_pc_nx = bus.pc_in;
                        state_nx  = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.inst_addr_ok)
                    state_nx = bus.flush ? DISCARD : WAIT;
                else if (bus.flush)
                    state_nx = IDLE;
            end
            WAIT: begin
                if (bus.flush) begin
                    state_nx = bus.inst_data_ok ? IDLE : DISCARD;
                end else if (bus.inst_data_ok) begin
                    push       = 1'b1;
                    push_entry = '{pc: req_pc, inst: bus.inst_rdata, adel: 1'b0};
                    state_nx   = IDLE;
                end
            end
            DISCARD: begin
                if (bus.inst_data_ok)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            req_pc <= 32'h0;
        end else begin
            state  <= state_nx;
            req_pc <= req_pc_nx;
        end
    end

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            q[0]   <= '0;
            q[1]   <= '0;
        end else if (bus.flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                q[wr_ptr] <= push_entry;
                wr_ptr    <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_ifetch_in_if.sv
// Directed self-checking bench for ifetch_in_if.
module tb_ifetch_in_if;
    logic clk;
    logic reset;
    int   total;
    int   passed;

    ifetch_in_if_if bif ();

    ifetch_in_if dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total = total + 1;
        assert (obs === want) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    endtask

    // Accept, immediate addr_ok, immediate data_ok; ends just after the push edge.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data);
        bif.pc_in    = pc;
        bif.pc_valid = 1'b1;
        #1;
        chk("fetch_accept", 32'(bif.pc_accept), 32'h1);
        tick();
        bif.pc_valid     = 1'b0;
        bif.inst_addr_ok = 1'b1;
        tick();
        bif.inst_addr_ok = 1'b0;
        bif.inst_data_ok = 1'b1;
        bif.inst_rdata   = data;
        tick();
        bif.inst_data_ok = 1'b0;
    endtask

    initial begin
        total            = 0;
        passed           = 0;
        reset            = 1'b1;
        bif.pc_in        = 32'h0;
        bif.pc_valid     = 1'b1;
        bif.flush        = 1'b0;
        bif.inst_addr_ok = 1'b0;
        bif.inst_data_ok = 1'b0;
        bif.inst_rdata   = 32'h0;
        bif.id_ready     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_pc_accept", 32'(bif.pc_accept), 32'h0);
        chk("rst_inst_req",  32'(bif.inst_req),  32'h0);
        chk("rst_inst_addr", bif.inst_addr,      32'h0);
        chk("rst_id_valid",  32'(bif.id_valid),  32'h0);
        chk("rst_id_pc",     bif.id_pc,          32'h0);
        chk("rst_id_inst",   bif.id_inst,        32'h0);
        chk("rst_id_adel",   32'(bif.id_adel),   32'h0);
        bif.pc_valid = 1'b0;
        reset        = 1'b0;
        tick();

        // Minimum latency fetch
        bif.pc_in    = 32'hbfc00000;
        bif.pc_valid = 1'b1;
        #1;
        chk("lat_accept", 32'(bif.pc_accept), 32'h1);
        tick();
        bif.pc_valid     = 1'b0;
        bif.inst_addr_ok = 1'b1;
        #1;
        chk("lat_inst_req",  32'(bif.inst_req),  32'h1);
        chk("lat_inst_addr", bif.inst_addr,      32'hbfc00000);
        chk("lat_no_accept", 32'(bif.pc_accept), 32'h0);
        tick();
        bif.inst_addr_ok = 1'b0;
        bif.inst_data_ok = 1'b1;
        bif.inst_rdata   = 32'h24080001;
        chk("lat_c2_id_valid", 32'(bif.id_valid), 32'h0);
        tick();
        bif.inst_data_ok = 1'b0;
        chk("lat_c3_id_valid", 32'(bif.id_valid), 32'h1);
        chk("lat_c3_id_pc",    bif.id_pc,         32'hbfc00000);
        chk("lat_c3_id_inst",  bif.id_inst,       32'h24080001);
        chk("lat_c3_id_adel",  32'(bif.id_adel),  32'h0);
        bif.id_ready = 1'b1;
        tick();
        bif.id_ready = 1'b0;
        chk("lat_pop_empty", 32'(bif.id_valid), 32'h0);

        // Two entries queue with ID stalled; third PC blocked until a pop
        fetch(32'hbfc00000, 32'h11111111);
        fetch(32'hbfc00004, 32'h22222222);
        bif.pc_in    = 32'hbfc00008;
        bif.pc_valid = 1'b1;
        #1;
        chk("full_no_accept", 32'(bif.pc_accept), 32'h0);
        tick();
        chk("full_no_accept2", 32'(bif.pc_accept), 32'h0);
        chk("full_no_req",     32'(bif.inst_req),  32'h0);
        chk("full_head_pc",    bif.id_pc,          32'hbfc00000);
        chk("full_head_inst",  bif.id_inst,        32'h11111111);
        bif.id_ready = 1'b1;
        tick();
        bif.id_ready = 1'b0;
        chk("pop1_head_pc",   bif.id_pc,          32'hbfc00004);
        chk("pop1_head_inst", bif.id_inst,        32'h22222222);
        chk("pop1_accept",    32'(bif.pc_accept), 32'h1);
        tick();
        bif.pc_valid     = 1'b0;
        bif.inst_addr_ok = 1'b1;
        chk("q08_inst_addr", bif.inst_addr, 32'hbfc00008);
        tick();
        bif.inst_addr_ok = 1'b0;
        bif.inst_data_ok = 1'b1;
        bif.inst_rdata   = 32'h33333333;
        tick();
        bif.inst_data_ok = 1'b0;
        bif.id_ready     = 1'b1;
        chk("q_order_04", bif.id_pc, 32'hbfc00004);
        tick();
        chk("q_order_08",      bif.id_pc,   32'hbfc00008);
        chk("q_order_08_inst", bif.id_inst, 32'h33333333);
        tick();
        bif.id_ready = 1'b0;
        chk("q_drained", 32'(bif.id_valid), 32'h0);

        // Flush blocks accept in IDLE
        bif.pc_in    = 32'hbfc00010;
        bif.pc_valid = 1'b1;
        bif.flush    = 1'b1;
        #1;
        chk("flush_idle_no_accept", 32'(bif.pc_accept), 32'h0);
        bif.flush = 1'b0;
        #1;

        // Flush in WAIT; late data dropped
        tick();
        bif.pc_valid     = 1'b0;
        bif.inst_addr_ok = 1'b1;
        tick();
        bif.inst_addr_ok = 1'b0;
        bif.flush        = 1'b1;
        tick();
        bif.flush    = 1'b0;
        bif.pc_in    = 32'hbfc00014;
        bif.pc_valid = 1'b1;
        #1;
        chk("discard_no_req",    32'(bif.inst_req),  32'h0);
        chk("discard_no_accept", 32'(bif.pc_accept), 32'h0);
        chk("discard_id_valid",  32'(bif.id_valid),  32'h0);
        tick();
        bif.inst_data_ok = 1'b1;
        bif.inst_rdata   = 32'hdeadbeef;
        tick();
        bif.inst_data_ok = 1'b0;
        #1;
        chk("drop_id_valid",  32'(bif.id_valid),  32'h0);
        chk("drop_accept_ok", 32'(bif.pc_accept), 32'h1);
        tick();
        bif.pc_valid     = 1'b0;
        bif.inst_addr_ok = 1'b1;
        chk("after_flush_addr", bif.inst_addr, 32'hbfc00014);
        tick();
        bif.inst_addr_ok = 1'b0;
        bif.inst_data_ok = 1'b1;
        bif.inst_rdata   = 32'haaaa0014;
        tick();
        bif.inst_data_ok = 1'b0;
        chk("after_flush_valid", 32'(bif.id_valid), 32'h1);
        chk("after_flush_inst",  bif.id_inst,       32'haaaa0014);

        // Flush with pop and returning data at count 1
        bif.pc_in    = 32'hbfc00018;
        bif.pc_valid = 1'b1;
        tick();
        bif.pc_valid     = 1'b0;
        bif.inst_addr_ok = 1'b1;
        tick();
        bif.inst_addr_ok = 1'b0;
        bif.inst_data_ok = 1'b1;
        bif.inst_rdata   = 32'h55555555;
        bif.id_ready     = 1'b1;
        bif.flush        = 1'b1;
        tick();
        bif.inst_data_ok = 1'b0;
        bif.id_ready     = 1'b0;
        bif.flush        = 1'b0;
        chk("fpp_id_valid", 32'(bif.id_valid), 32'h0);
        tick();
        chk("fpp_id_valid2", 32'(bif.id_valid), 32'h0);
        chk("fpp_no_req",    32'(bif.inst_req), 32'h0);

        // Flush in REQ without addr_ok withdraws the request
        bif.pc_in    = 32'hbfc0001c;
        bif.pc_valid = 1'b1;
        tick();
        bif.pc_valid = 1'b0;
        bif.flush    = 1'b1;
        #1;
        chk("wd_req_high", 32'(bif.inst_req), 32'h1);
        tick();
        bif.flush = 1'b0;
        chk("wd_req_low", 32'(bif.inst_req), 32'h0);
        bif.pc_valid = 1'b1;
        #1;
        chk("wd_idle_accept", 32'(bif.pc_accept), 32'h1);
        bif.pc_valid = 1'b0;

        // Reset mid-WAIT; late data ignored
        fetch(32'hbfc00020, 32'h66666666);
        bif.id_ready = 1'b1;
        tick();
        bif.id_ready = 1'b0;
        bif.pc_in    = 32'hbfc00024;
        bif.pc_valid = 1'b1;
        tick();
        bif.pc_valid     = 1'b0;
        bif.inst_addr_ok = 1'b1;
        tick();
        bif.inst_addr_ok = 1'b0;
        reset            = 1'b1;
        #1;
        chk("rw_inst_req", 32'(bif.inst_req), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        bif.inst_data_ok = 1'b1;
        bif.inst_rdata   = 32'h77777777;
        tick();
        bif.inst_data_ok = 1'b0;
        chk("rw_id_valid",  32'(bif.id_valid), 32'h0);
        tick();
        chk("rw_id_valid2", 32'(bif.id_valid), 32'h0);
        chk("rw_inst_addr", bif.inst_addr,     32'h0);

`ifdef IF_ALIGN_CHECK_EN
        // Misaligned PC becomes an address-error entry without a bus request
        bif.pc_in    = 32'hbfc00002;
        bif.pc_valid = 1'b1;
        #1;
        chk("al_accept", 32'(bif.pc_accept), 32'h1);
        chk("al_no_req", 32'(bif.inst_req),  32'h0);
        tick();
        bif.pc_valid = 1'b0;
        #1;
        chk("al_no_req2",  32'(bif.inst_req), 32'h0);
        chk("al_id_valid", 32'(bif.id_valid), 32'h1);
        chk("al_id_adel",  32'(bif.id_adel),  32'h1);
        chk("al_id_inst",  bif.id_inst,       32'h0);
        chk("al_id_pc",    bif.id_pc,         32'hbfc00002);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
